// File: rtl/uart_rx_fifo.sv
// Receive byte buffer behind the UART receiver: rising-edge capture of data_ready into a FWFT FIFO.
// Optional sticky overrun flag enabled by defining UART_RX_FIFO_OVERRUN_EN.
module uart_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              rd_en,
  output logic [7:0]        rd_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overrun,
  input  logic              clr_overrun
);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_q;
  logic              rx_valid_d;
  logic              wr;
  logic              wr_fire;
  logic              rd_fire;
  logic              drop;

  // Handshake: rd_data/empty form the head "valid" (valid = ~empty); rd_en acts as
  // ready and a byte transfers on any rising clk edge where rd_en & ~empty.
  assign wr      = rx_valid & ~rx_valid_d;
  assign rd_fire = rd_en & ~empty;
  assign wr_fire = wr & (~full | rd_fire);
  assign drop    = wr & full & ~rd_fire;

  assign count   = count_q;
  assign empty   = (count_q == '0);
  assign full    = (count_q == (ADDR_W+1)'(DEPTH));
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_valid_d <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      rx_valid_d <= rx_valid;
      if (wr_fire) begin
        mem[wr_ptr] <= rx_data;
        wr_ptr      <= wr_ptr + ADDR_W'(1);
      end
      if (rd_fire) rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({wr_fire, rd_fire})
        2'b10:   count_q <= count_q + (ADDR_W+1)'(1);
        2'b01:   count_q <= count_q - (ADDR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef UART_RX_FIFO_OVERRUN_EN
  logic overrun_q;

  // A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            overrun_q <= 1'b0;
    else if (drop)        overrun_q <= 1'b1;
    else if (clr_overrun) overrun_q <= 1'b0;
  end

  assign overrun = overrun_q;
`else
  logic unused_ovr;

  assign overrun    = 1'b0;
  assign unused_ovr = clr_overrun | drop;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: per-cycle vector table plus hand-written multi-cycle sequences.
module tb_uart_rx_fifo;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
`ifdef UART_RX_FIFO_OVERRUN_EN
  localparam logic EXP_OV = 1'b1;
`else
  localparam logic EXP_OV = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic [7:0]      rx_data;
  logic            rx_valid;
  logic            rd_en;
  logic [7:0]      rd_data;
  logic            empty;
  logic            full;
  logic [ADDR_W:0] count;
  logic            overrun;
  logic            clr_overrun;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  logic       exp_ov;

  typedef struct {
    logic       rv;
    logic [7:0] din;
    logic       re;
    logic [4:0] c;
    logic       e;
    logic       f;
    logic [7:0] q;
  } vec_t;
  vec_t vecs[9];

  uart_rx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .full(full),
    .count(count), .overrun(overrun), .clr_overrun(clr_overrun)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // driver tasks, each keeping the scoreboard in step with the stimulus
  task automatic push(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    if (exp_q.size() < DEPTH) exp_q.push_back(b);
    else exp_ov = EXP_OV;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("drain_data", 16'(rd_data), 16'(exp_q.pop_front()));
      rd_en = 1'b1;
    end
    @(negedge clk);
    rd_en = 1'b0;
    check("drain_count", 16'(count), 16'(exp_q.size()));
    check("drain_empty", 16'(empty), 16'(exp_q.size() == 0));
  endtask

  task automatic fill(input logic [7:0] base);
    for (int i = 0; i < DEPTH; i++) push(base + 8'(i));
  endtask

  initial begin
    reset = 1'b1; rx_data = '0; rx_valid = 1'b0; rd_en = 1'b0; clr_overrun = 1'b0;
    exp_ov = 1'b0;

    //        rv   din    re  count empty full rd_data
    vecs[0] = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 8'h00};
    vecs[1] = '{1'b1, 8'h41, 1'b0, 5'd1, 1'b0, 1'b0, 8'h41};
    vecs[2] = '{1'b1, 8'h41, 1'b0, 5'd1, 1'b0, 1'b0, 8'h41};
    vecs[3] = '{1'b1, 8'h99, 1'b0, 5'd1, 1'b0, 1'b0, 8'h41};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 8'h00};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 8'h00};
    vecs[6] = '{1'b1, 8'h7A, 1'b1, 5'd1, 1'b0, 1'b0, 8'h7A};
    vecs[7] = '{1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 1'b0, 8'h7A};
    vecs[8] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 8'h00};

    // reset state
    #3;
    check("rst_count", 16'(count), 16'd0);
    check("rst_empty", 16'(empty), 16'd1);
    check("rst_full", 16'(full), 16'd0);
    check("rst_rd_data", 16'(rd_data), 16'd0);
    check("rst_overrun", 16'(overrun), 16'd0);
    @(negedge clk);
    reset = 1'b0;

    // table: edge detect, held level, pop on empty, push+pop on empty
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      rx_valid = vecs[i].rv;
      rx_data  = vecs[i].din;
      rd_en    = vecs[i].re;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_count", i), 16'(count), 16'(vecs[i].c));
      check($sformatf("vec%0d_empty", i), 16'(empty), 16'(vecs[i].e));
      check($sformatf("vec%0d_full", i), 16'(full), 16'(vecs[i].f));
      check($sformatf("vec%0d_rd_data", i), 16'(rd_data), 16'(vecs[i].q));
    end
    @(negedge clk);
    rd_en = 1'b0; rx_valid = 1'b0;

    // level held 20 cycles gives one entry
    @(negedge clk);
    rx_data = 8'h41; rx_valid = 1'b1;
    exp_q.push_back(8'h41);
    repeat (20) @(negedge clk);
    check("hold20_count", 16'(count), 16'd1);
    check("hold20_rd_data", 16'(rd_data), 16'h41);
    rx_valid = 1'b0;
    drain(1);

    // fill 0x01..0x10, back-to-back drain
    fill(8'h01);
    check("fill_full", 16'(full), 16'd1);
    check("fill_count", 16'(count), 16'd16);
    drain(16);

    // overrun: 17th byte dropped
    fill(8'h01);
    push(8'hEE);
    check("ovr_count", 16'(count), 16'd16);
    check("ovr_flag", 16'(overrun), 16'(exp_ov));
    @(negedge clk); clr_overrun = 1'b1;
    @(negedge clk); clr_overrun = 1'b0;
    exp_ov = 1'b0;
    check("ovr_clr", 16'(overrun), 16'(exp_ov));

    // drop and clear in the same cycle: set wins
    @(negedge clk);
    clr_overrun = 1'b1; rx_data = 8'hEF; rx_valid = 1'b1;
    exp_ov = EXP_OV;
    @(negedge clk);
    clr_overrun = 1'b0; rx_valid = 1'b0;
    check("ovr_setwins", 16'(overrun), 16'(exp_ov));
    check("ovr_setwins_count", 16'(count), 16'd16);
    @(negedge clk); clr_overrun = 1'b1;
    @(negedge clk); clr_overrun = 1'b0;
    exp_ov = 1'b0;
    drain(16);

    // full FIFO: push and pop in the same cycle
    fill(8'h20);
    @(negedge clk);
    rx_data = 8'h55; rx_valid = 1'b1; rd_en = 1'b1;
    check("fullpp_head", 16'(rd_data), 16'(exp_q.pop_front()));
    exp_q.push_back(8'h55);
    @(negedge clk);
    rx_valid = 1'b0; rd_en = 1'b0;
    check("fullpp_count", 16'(count), 16'd16);
    check("fullpp_overrun", 16'(overrun), 16'd0);
    drain(16);

    // asynchronous reset mid-stream, rx_valid high across release
    for (int i = 0; i < 5; i++) push(8'h60 + 8'(i));
    check("pre_rst_count", 16'(count), 16'd5);
    @(negedge clk);
    #2;
    reset = 1'b1; rx_data = 8'h33; rx_valid = 1'b1;
    #1;
    check("midrst_count", 16'(count), 16'd0);
    check("midrst_empty", 16'(empty), 16'd1);
    check("midrst_rd_data", 16'(rd_data), 16'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    exp_q.push_back(8'h33);
    @(negedge clk);
    check("relrst_count", 16'(count), 16'd1);
    check("relrst_rd_data", 16'(rd_data), 16'h33);
    rx_valid = 1'b0;
    drain(1);

    // wrap: 40 push/pop pairs
    for (int i = 0; i < 40; i++) begin
      push(8'h80 + 8'(i));
      drain(1);
    end

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
